// File: rtl/perf_pkg.sv
// Shared types and constants for the performance event counter bank.
//   perf_state_e : bank operating state (RUN / FROZEN / TIMEOUT)
//   EV_*         : channel assignments for the core stall/flush strobes
package perf_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FROZEN  = 2'd1,
    TIMEOUT = 2'd2
  } perf_state_e;

  localparam int unsigned EV_BRANCH_FLUSH = 0;
  localparam int unsigned EV_MULT_STALL   = 1;
  localparam int unsigned EV_DIV_STALL    = 2;

endpackage

// File: rtl/perf_counter_cell.sv
// One event-counter channel with sticky overflow.
//   clk, rst  : clock, asynchronous active-high reset
//   inc       : count one event this cycle (already gated by bank state)
//   clear     : synchronous clear of count and overflow; wins over inc
//   count     : current counter value
//   overflow  : sticky, set by an increment at all-ones
// SATURATE != 0 holds the count at all-ones on overflow; otherwise it wraps.
module perf_counter_cell #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (inc) begin
      if (count == '1) begin
        overflow <= 1'b1;
        count    <= (SATURATE != 0) ? '1 : '0;
      end else begin
        count <= count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/perf_event_counter_bank.sv
// N-channel event counter bank with a run-time watchdog.
//   clk, rst   : clock, asynchronous active-high reset
//   event_i    : per-channel event strobes, one count per high cycle
//   enable     : global count enable
//   clear      : zero counters/overflow, reload watchdog, return to RUN
//   halt       : core halted; moves the bank to FROZEN
//   rd_req     : readout request for channel rd_idx
//   rd_resp    : readout valid, one cycle after rd_req
//   rd_data    : count of the requested channel as registered at the request cycle
//   overflow   : sticky per-channel overflow flags
//   frozen     : bank is in FROZEN
//   timeout    : bank is in TIMEOUT (watchdog expired)
module perf_event_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned NUM_EVENTS     = 4,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned SATURATE       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter int unsigned TO_WIDTH       = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_EVENTS-1:0]                 event_i,
  input  logic                                  enable,
  input  logic                                  clear,
  input  logic                                  halt,
  input  logic                                  rd_req,
  input  logic [($clog2(NUM_EVENTS) | 1)-1:0]   rd_idx,
  output logic                                  rd_resp,
  output logic [CNT_WIDTH-1:0]                  rd_data,
  output logic [NUM_EVENTS-1:0]                 overflow,
  output logic                                  frozen,
  output logic                                  timeout
);

  localparam int unsigned IDX_W = $clog2(NUM_EVENTS) | 1;
  localparam logic [TO_WIDTH-1:0] WD_RELOAD = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  perf_state_e         state;
  logic [TO_WIDTH-1:0] wd;
  logic                count_en;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_EVENTS];
  logic [IDX_W-1:0]    rd_idx_q;

  // State FSM and watchdog; frozen/timeout are registered state decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      wd      <= WD_RELOAD;
      frozen  <= 1'b0;
      timeout <= 1'b0;
    end else if (clear) begin
      state   <= RUN;
      wd      <= WD_RELOAD;
      frozen  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt) begin
            state  <= FROZEN;
            frozen <= 1'b1;
          end else if (wd == '0) begin
            state   <= TIMEOUT;
            timeout <= 1'b1;
          end else begin
            wd <= wd - TO_WIDTH'(1);
          end
        end
        default: ; // FROZEN and TIMEOUT hold until clear
      endcase
    end
  end

  // The halt cycle itself is excluded from counting.
  assign count_en = (state == RUN) && enable && !halt && !clear;

  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_cell
    perf_counter_cell #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .inc      (count_en && event_i[g]),
      .clear    (clear),
      .count    (cnt_q[g]),
      .overflow (overflow[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_resp  <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      rd_resp <= rd_req;
      if (rd_req) begin
        rd_idx_q <= rd_idx;
      end
    end
  end

  // Selecting from the counter registers in the response cycle yields exactly the
  // value registered at the end of the request cycle, including that cycle's increment,
  // without duplicating the counter's next-state logic here.
  always_comb begin
    rd_data = '0;
    if (rd_resp) begin
      for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
        if (32'(rd_idx_q) == i) begin
          rd_data = cnt_q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_perf_event_counter_bank.sv
module tb_perf_event_counter_bank;
  import perf_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] event_i;
  logic       enable, clear, halt, rd_req;
  logic [2:0] rd_idx;

  // m: default widths; s: 4-bit saturating; w: 4-bit wrapping; t: short watchdog
  logic        m_resp, s_resp, w_resp, t_resp;
  logic [31:0] m_data;
  logic [3:0]  s_data, w_data;
  logic [7:0]  t_data;
  logic [3:0]  m_ovf, s_ovf, w_ovf, t_ovf;
  logic        m_frz, s_frz, w_frz, t_frz;
  logic        m_to, s_to, w_to, t_to;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  perf_event_counter_bank #(.NUM_EVENTS(4)) u_m (
    .clk(clk), .rst(rst), .event_i(event_i), .enable(enable), .clear(clear), .halt(halt),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_resp(m_resp), .rd_data(m_data),
    .overflow(m_ovf), .frozen(m_frz), .timeout(m_to));

  perf_event_counter_bank #(.NUM_EVENTS(4), .CNT_WIDTH(4), .SATURATE(1)) u_s (
    .clk(clk), .rst(rst), .event_i(event_i), .enable(enable), .clear(clear), .halt(halt),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_resp(s_resp), .rd_data(s_data),
    .overflow(s_ovf), .frozen(s_frz), .timeout(s_to));

  perf_event_counter_bank #(.NUM_EVENTS(4), .CNT_WIDTH(4), .SATURATE(0)) u_w (
    .clk(clk), .rst(rst), .event_i(event_i), .enable(enable), .clear(clear), .halt(halt),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_resp(w_resp), .rd_data(w_data),
    .overflow(w_ovf), .frozen(w_frz), .timeout(w_to));

  perf_event_counter_bank #(.NUM_EVENTS(4), .CNT_WIDTH(8), .TIMEOUT_CYCLES(10), .TO_WIDTH(8)) u_t (
    .clk(clk), .rst(rst), .event_i(event_i), .enable(enable), .clear(clear), .halt(halt),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_resp(t_resp), .rd_data(t_data),
    .overflow(t_ovf), .frozen(t_frz), .timeout(t_to));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; event_i = '0; enable = 1'b0; clear = 1'b0; halt = 1'b0;
    rd_req = 1'b0; rd_idx = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp", 32'(m_resp), 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_ovf", 32'(m_ovf), 32'd0);
    chk("rst_frozen", 32'(m_frz), 32'd0);
    chk("rst_timeout", 32'(m_to), 32'd0);
    rst = 1'b0;

    // 1: five pulses on ch1, readout latency one cycle
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      event_i = 4'b0010; step();
      event_i = 4'b0000; step();
    end
    rd_req = 1'b1; rd_idx = 3'd1; step();
    rd_req = 1'b0;
    chk("t1_resp", 32'(m_resp), 32'd1);
    chk("t1_data", m_data, 32'd5);
    step();
    chk("t1_noreq_resp", 32'(m_resp), 32'd0);
    event_i = 4'b0010; rd_req = 1'b1; rd_idx = 3'd1; step();
    event_i = 4'b0000; rd_req = 1'b0;
    chk("t1_same_cycle_inc", m_data, 32'd6);

    // 2: saturate vs wrap on 4-bit counters
    clear = 1'b1; step(); clear = 1'b0;
    event_i = 4'b0001;
    repeat (15) step();
    chk("t2_w_ovf_before", 32'(w_ovf[0]), 32'd0);
    rd_req = 1'b1; rd_idx = 3'd0; step();
    chk("t2_s_16", 32'(s_data), 32'd15);
    chk("t2_w_16", 32'(w_data), 32'd0);
    chk("t2_m_16", m_data, 32'd16);
    chk("t2_s_ovf", 32'(s_ovf[0]), 32'd1);
    chk("t2_w_ovf", 32'(w_ovf[0]), 32'd1);
    step();
    rd_req = 1'b0; event_i = 4'b0000;
    chk("t2_s_17", 32'(s_data), 32'd15);
    chk("t2_w_17", 32'(w_data), 32'd1);
    chk("t2_w_ovf_sticky", 32'(w_ovf[0]), 32'd1);

    // 3: event coincident with halt is dropped; frozen ignores events
    clear = 1'b1; step(); clear = 1'b0;
    chk("t3_clr_ovf", 32'(s_ovf), 32'd0);
    event_i = 4'b0100;
    repeat (3) step();
    halt = 1'b1; step();
    halt = 1'b0;
    chk("t3_frozen", 32'(m_frz), 32'd1);
    chk("t3_not_timeout", 32'(m_to), 32'd0);
    repeat (2) step();
    event_i = 4'b0000;
    rd_req = 1'b1; rd_idx = 3'(EV_DIV_STALL); step();
    rd_req = 1'b0;
    chk("t3_ch2_held", m_data, 32'd3);
    chk("t3_still_frozen", 32'(m_frz), 32'd1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("t3_unfrozen", 32'(m_frz), 32'd0);
    rd_req = 1'b1; rd_idx = 3'(EV_DIV_STALL); step();
    rd_req = 1'b0;
    chk("t3_ch2_cleared", m_data, 32'd0);

    // 4: watchdog of 10 cycles
    clear = 1'b1; step(); clear = 1'b0;
    event_i = 4'b0001;
    repeat (9) step();
    chk("t4_to_at9", 32'(t_to), 32'd0);
    step();
    chk("t4_to_at10", 32'(t_to), 32'd1);
    chk("t4_to_not_frozen", 32'(t_frz), 32'd0);
    repeat (2) step();
    event_i = 4'b0000;
    rd_req = 1'b1; rd_idx = 3'd0; step();
    rd_req = 1'b0;
    chk("t4_count_stop", 32'(t_data), 32'd10);
    chk("t4_resp_in_timeout", 32'(t_resp), 32'd1);
    clear = 1'b1; step(); clear = 1'b0;
    repeat (9) step();
    clear = 1'b1; step(); clear = 1'b0;
    chk("t4_clr_vs_expiry", 32'(t_to), 32'd0);
    step();
    chk("t4_reloaded", 32'(t_to), 32'd0);
    repeat (8) step();
    halt = 1'b1; step(); halt = 1'b0;
    chk("t4_halt_prio_frz", 32'(t_frz), 32'd1);
    chk("t4_halt_prio_to", 32'(t_to), 32'd0);

    // 5: back-to-back reads including out-of-range index
    clear = 1'b1; step(); clear = 1'b0;
    event_i = 4'b0011; repeat (2) step();
    event_i = 4'b0001; step();
    event_i = 4'b0000;
    rd_req = 1'b1; rd_idx = 3'd0; step();
    chk("t5_r0_resp", 32'(m_resp), 32'd1);
    chk("t5_r0_data", m_data, 32'd3);
    rd_idx = 3'd1; step();
    chk("t5_r1_resp", 32'(m_resp), 32'd1);
    chk("t5_r1_data", m_data, 32'd2);
    rd_idx = 3'd4; step();
    chk("t5_r4_resp", 32'(m_resp), 32'd1);
    chk("t5_r4_data", m_data, 32'd0);
    rd_req = 1'b0; step();
    chk("t5_idle_resp", 32'(m_resp), 32'd0);

    // 6: asynchronous reset with a read outstanding
    halt = 1'b1; rd_req = 1'b1; rd_idx = 3'd0; step();
    halt = 1'b0;
    chk("t6_pre_resp", 32'(m_resp), 32'd1);
    chk("t6_pre_data", m_data, 32'd3);
    chk("t6_pre_frozen", 32'(m_frz), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_resp", 32'(m_resp), 32'd0);
    chk("t6_rst_data", m_data, 32'd0);
    chk("t6_rst_frozen", 32'(m_frz), 32'd0);
    rd_req = 1'b0;
    step();
    chk("t6_rst_hold_resp", 32'(m_resp), 32'd0);
    rst = 1'b0;
    step();
    chk("t6_no_late_resp", 32'(m_resp), 32'd0);
    rd_req = 1'b1; rd_idx = 3'd0; step();
    rd_req = 1'b0;
    chk("t6_count_zero", m_data, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
